// File: rtl/par_port_ctrl.sv
// par_port_ctrl: WIDTH-bit bidirectional parallel port with synchronised, edge-detected pin interrupts
module par_port_ctrl #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] DIR_RST     = '0,
    parameter logic [WIDTH-1:0] OUT_RST     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);
    localparam logic [2:0] A_DIR  = 3'd0;
    localparam logic [2:0] A_OUT  = 3'd1;
    localparam logic [2:0] A_SET  = 3'd2;
    localparam logic [2:0] A_CLR  = 3'd3;
    localparam logic [2:0] A_IN   = 3'd4;
    localparam logic [2:0] A_IEN  = 3'd5;
    localparam logic [2:0] A_STAT = 3'd6;
    localparam logic [2:0] A_EDGE = 3'd7;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] dir_q, dir_d, out_q, out_d, ien_q, ien_d, edge_q, edge_d;
    logic [WIDTH-1:0] stat_q, stat_d, prev_q, rdata_q, rdata_d;
    logic [WIDTH-1:0] sync, events, w1c;

    assign rdata   = rdata_q;
    assign pin_out = out_q;
    assign pin_oe  = dir_q;
    assign irq     = |(stat_q & ien_q);

    // Next-state: register writes, edge events (input bits only), sticky status with set beating W1C, read mux
    always_comb begin
        sync   = sync_q[SYNC_STAGES-1];
        events = ((sync & ~prev_q & edge_q) | (~sync & prev_q & ~edge_q)) & ~dir_q;
        dir_d  = (wr_en && addr == A_DIR) ? wdata : dir_q;
        out_d  = !wr_en          ? out_q :
                 addr == A_OUT   ? wdata :
                 addr == A_SET   ? out_q | wdata :
                 addr == A_CLR   ? out_q & ~wdata : out_q;
        ien_d  = (wr_en && addr == A_IEN) ? wdata : ien_q;
        edge_d = (wr_en && addr == A_EDGE) ? wdata : edge_q;
        w1c    = (wr_en && addr == A_STAT) ? wdata : '0;
        stat_d = (stat_q & ~w1c) | events;
        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                A_DIR:   rdata_d = dir_q;
                A_OUT:   rdata_d = out_q;
                A_IN:    rdata_d = sync;
                A_IEN:   rdata_d = ien_q;
                A_STAT:  rdata_d = stat_q;
                A_EDGE:  rdata_d = edge_q;
                default: rdata_d = '0;
            endcase
        end
    end

    // State registers, synchroniser chain and previous-sample tracker
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q   <= DIR_RST;
            out_q   <= OUT_RST;
            ien_q   <= '0;
            edge_q  <= '0;
            stat_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
        end else begin
            dir_q   <= dir_d;
            out_q   <= out_d;
            ien_q   <= ien_d;
            edge_q  <= edge_d;
            stat_q  <= stat_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_in};
            prev_q  <= sync;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_par_port_ctrl.sv
// tb_par_port_ctrl: table vectors, hand corner sequences and random traffic against a delay-line register model
module tb_par_port_ctrl;
    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0, rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [2:0]   addr = '0;
    logic [W-1:0] wdata = '0, pin_in = '0;
    logic [W-1:0] rdata, pin_out, pin_oe;
    logic         irq;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_reg [8];
    logic [W-1:0] m_rdata;
    logic [W-1:0] hist [$];

    typedef struct {
        logic         wr;
        logic         rd;
        logic [2:0]   a;
        logic [W-1:0] d;
        logic [W-1:0] exp_rdata;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_oe;
    } vec_t;
    vec_t tbl [16];

    par_port_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_rdata = '0;
        hist.delete();
        repeat (S + 1) hist.push_back('0);
    endtask

    // hist[0] is the pin value sampled at the latest edge; IN is the value S edges back
    task automatic model_step();
        logic [W-1:0] sync = hist[S-1];
        logic [W-1:0] prev = hist[S];
        logic [W-1:0] ev = '0;
        for (int i = 0; i < W; i++)
            if (!m_reg[0][i] && sync[i] != prev[i] && sync[i] == m_reg[7][i]) ev[i] = 1'b1;
        if (rd_en) m_rdata = (addr == 3'd2 || addr == 3'd3) ? '0 : (addr == 3'd4) ? sync : m_reg[addr];
        if (wr_en) begin
            case (addr)
                3'd2:    m_reg[1] = m_reg[1] | wdata;
                3'd3:    m_reg[1] = m_reg[1] & ~wdata;
                3'd4:    ;
                3'd6:    m_reg[6] = m_reg[6] & ~wdata;
                default: m_reg[addr] = wdata;
            endcase
        end
        m_reg[6] = m_reg[6] | ev;
        hist.push_front(pin_in);
        hist.delete(S + 1);
    endtask

    task automatic cyc(input logic w, input logic r, input logic [2:0] a, input logic [W-1:0] d);
        wr_en = w; rd_en = r; addr = a; wdata = d;
        @(posedge clk);
        model_step();
        #1;
        chk("model_pin_out", pin_out, m_reg[1]);
        chk("model_pin_oe", pin_oe, m_reg[0]);
        chk("model_rdata", rdata, m_rdata);
        chk("model_irq", irq, |(m_reg[6] & m_reg[5]));
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 3'd0, '0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [W-1:0] exp, input string n);
        cyc(1'b0, 1'b1, a, '0);
        chk(n, rdata, exp);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_pin_oe", pin_oe, 0);
        chk("rst_pin_out", pin_out, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'hF0, 8'h00, 8'h00, 8'hF0};
        tbl[1]  = '{1'b1, 1'b0, 3'd1, 8'h3C, 8'h00, 8'h3C, 8'hF0};
        tbl[2]  = '{1'b1, 1'b0, 3'd2, 8'h81, 8'h00, 8'hBD, 8'hF0};
        tbl[3]  = '{1'b1, 1'b0, 3'd3, 8'h0C, 8'h00, 8'hB1, 8'hF0};
        tbl[4]  = '{1'b0, 1'b1, 3'd1, 8'h00, 8'hB1, 8'hB1, 8'hF0};
        tbl[5]  = '{1'b0, 1'b1, 3'd2, 8'h00, 8'h00, 8'hB1, 8'hF0};
        tbl[6]  = '{1'b0, 1'b1, 3'd0, 8'h00, 8'hF0, 8'hB1, 8'hF0};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hF0, 8'hB1, 8'hF0};
        tbl[8]  = '{1'b1, 1'b1, 3'd1, 8'h55, 8'hB1, 8'h55, 8'hF0};
        tbl[9]  = '{1'b0, 1'b1, 3'd1, 8'h00, 8'h55, 8'h55, 8'hF0};
        tbl[10] = '{1'b1, 1'b0, 3'd4, 8'hFF, 8'h55, 8'h55, 8'hF0};
        tbl[11] = '{1'b0, 1'b1, 3'd4, 8'h00, 8'h00, 8'h55, 8'hF0};
        tbl[12] = '{1'b1, 1'b1, 3'd0, 8'h0F, 8'hF0, 8'h55, 8'h0F};
        tbl[13] = '{1'b1, 1'b0, 3'd3, 8'hFF, 8'hF0, 8'h00, 8'h0F};
        tbl[14] = '{1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 8'h00, 8'h0F};
        tbl[15] = '{1'b0, 1'b1, 3'd7, 8'h00, 8'h00, 8'h00, 8'h0F};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        chk("init_pin_oe", pin_oe, 0);
        chk("init_pin_out", pin_out, 0);
        chk("init_rdata", rdata, 0);
        chk("init_irq", irq, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_out", i), pin_out, tbl[i].exp_out);
            chk($sformatf("tbl%0d_oe", i), pin_oe, tbl[i].exp_oe);
        end

        cyc(1'b1, 1'b0, 3'd0, 8'h00);
        pin_in = 8'h55;
        rd(3'd4, 8'h00, "sync_lat1");
        rd(3'd4, 8'h00, "sync_lat2");
        rd(3'd4, 8'h55, "sync_lat3");

        pin_in = 8'h00;
        idle(4);
        cyc(1'b1, 1'b0, 3'd7, 8'h01);
        cyc(1'b1, 1'b0, 3'd5, 8'h03);
        cyc(1'b1, 1'b0, 3'd6, 8'hFF);
        idle(2);
        rd(3'd6, 8'h00, "stat_cleared");
        pin_in = 8'h01;
        idle(3);
        chk("irq_rise0", irq, 1);
        rd(3'd6, 8'h01, "stat_rise0");
        pin_in = 8'h03;
        idle(3);
        rd(3'd6, 8'h01, "stat_rise1_ignored");
        pin_in = 8'h01;
        idle(3);
        rd(3'd6, 8'h03, "stat_fall1");
        cyc(1'b1, 1'b0, 3'd6, 8'h01);
        rd(3'd6, 8'h02, "stat_w1c0");
        chk("irq_after_w1c0", irq, 1);
        cyc(1'b1, 1'b0, 3'd6, 8'h02);
        chk("irq_after_w1c1", irq, 0);

        pin_in = 8'h00;
        idle(3);
        pin_in = 8'h01;
        idle(3);
        pin_in = 8'h00;
        idle(3);
        pin_in = 8'h01;
        idle(2);
        cyc(1'b1, 1'b0, 3'd6, 8'h01);
        rd(3'd6, 8'h01, "stat_collision");

        cyc(1'b1, 1'b0, 3'd5, 8'h00);
        chk("irq_ien_off", irq, 0);
        cyc(1'b1, 1'b0, 3'd5, 8'h01);
        chk("irq_ien_late", irq, 1);

        cyc(1'b1, 1'b0, 3'd6, 8'hFF);
        cyc(1'b1, 1'b0, 3'd0, 8'h01);
        cyc(1'b1, 1'b0, 3'd1, 8'h00);
        pin_in = 8'h00;
        idle(3);
        pin_in = 8'h01;
        idle(3);
        rd(3'd6, 8'h00, "stat_masked");
        cyc(1'b1, 1'b0, 3'd0, 8'h00);
        idle(2);
        rd(3'd6, 8'h00, "stat_dir_release");
        pin_in = 8'h00;
        idle(3);
        pin_in = 8'h01;
        idle(3);
        rd(3'd6, 8'h01, "stat_unmasked");

        cyc(1'b1, 1'b0, 3'd0, 8'hFF);
        cyc(1'b1, 1'b0, 3'd1, 8'hA5);
        rd(3'd0, 8'hFF, "pre_rst_read");
        chk("pre_rst_irq", irq, 1);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pin_in = W'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            else cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
